dmem_responder: RTL and testbench
=================================

Name: dmem_responder

Overview:
- Responder (target) side of the pipelined core's data-memory interface, with a valid/ready request/response handshake.
- Accepts one load/store request from the memory stage.
- Inserts a programmable number of wait states, then performs the word access on an internal array and returns a response.
- Drives a busy flag that the hazard unit uses for stallF/stallD.
- Not pipelined: one transaction is outstanding at a time.

Parameters:
- ADDR_W, 8: word-address width; array depth = 2**ADDR_W 32-bit words.
- WAIT, 2: wait-state cycles between request acceptance and the access (0..15).
- BASE_ADDR, 32'h0000_0000: byte address of word 0; must be 4-byte aligned.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset (0 = reset asserted).
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_we  in  1  1 = store, 0 = load.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data.
- req_be  in  4  byte enables for stores; bit i enables bits [8i+7:8i]; ignored for loads.
- rsp_valid  out  1  response present.
- rsp_ready  in  1  requester accepts the response.
- rsp_rdata  out  32  load data; 0 for stores and errors.
- rsp_err  out  1  alignment or range error.
- busy  out  1  transaction in progress (state != IDLE).

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, wait counter=0.
  - Outputs: rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
  - All captured request registers are cleared.
  - Array contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- req_ready is high in IDLE and low in WAIT and RESP. It is combinational from state only.
- IDLE:
  - On req_valid & req_ready at a rising edge, capture we/addr/wdata/be and load counter=WAIT.
  - Next state is WAIT if WAIT>0, otherwise perform the access on that same edge and go to RESP.
- WAIT:
  - Counter decrements each cycle.
  - When counter==1, the next edge performs the access and enters RESP.
  - Total: rsp_valid first rises WAIT+1 cycles after the accepting edge.
  - WAIT=0 gives rsp_valid in the cycle after acceptance.
- Access, one edge, registered into rsp_* outputs:
  - err = (addr[1:0]!=0) | (addr < BASE_ADDR) | (addr >= BASE_ADDR + 4*2**ADDR_W).
  - Range compare uses 33-bit arithmetic so there is no wrap-around at 32'hFFFF_FFFC.
  - Word index = (addr - BASE_ADDR) >> 2, truncated to ADDR_W bits only after the range check passes.
  - Load, no error: rsp_rdata = mem[index].
  - Store, no error: mem[index] bytes with be=1 are updated; bytes with be=0 keep their value. rsp_rdata=0.
  - Store with be=4'b0000: legal, no change, err=0.
  - Any error: no array write, rsp_rdata=0, rsp_err=1.
- RESP:
  - rsp_valid=1; rsp_rdata and rsp_err stay stable until the handshake.
  - On rsp_valid & rsp_ready, go to IDLE and clear rsp_valid, rsp_rdata and rsp_err to 0.
  - rsp_ready held low leaves the block in RESP indefinitely.
- busy = (state != IDLE), registered from state. It is high from the cycle after acceptance through the response-handshake cycle.
- Input changes in WAIT/RESP are ignored; captured values are used.
- Reset mid-operation:
  - Reset in WAIT discards the transaction; a pending store is not committed, since the commit happens only on the access edge.
  - Reset in RESP drops the response; a store already committed stays committed.
- Load from a never-written location returns the array's power-up value; the bench must initialise the array before relying on it.

Test Plan:
- Reset: reset=0 mid-WAIT, then release -> next cycle state=IDLE, req_ready=1, busy=0, rsp_valid=0; the aborted store to 0x10 leaves mem[4] unchanged.
- Store/load, WAIT=2: store addr=0x10, wdata=32'hDEADBEEF, be=4'hF accepted at edge T -> rsp_valid high after T+3, err=0, rdata=0. Then load 0x10 -> rdata=32'hDEADBEEF.
- Byte enables: mem[1]=32'h11223344, store addr=0x4, wdata=32'hAABBCCDD, be=4'b0101 -> load 0x4 returns 32'h11BB33DD.
- Errors:
  - Load addr=0x6 -> rsp_err=1, rdata=0.
  - Store addr=BASE+0x400 with ADDR_W=8 -> rsp_err=1, array unchanged.
  - addr=32'hFFFF_FFFC -> rsp_err=1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_valid, rdata and err are held; req_ready=0 and a new req_valid is not accepted. rsp_ready=1 -> IDLE next cycle.
- Zero wait and throughput, WAIT=0: back-to-back requests with rsp_ready=1 -> each response one cycle after acceptance; one transaction per 2 cycles; busy toggles 1,0.

Source files
------------

// File: rtl/dmem_responder.sv
// ---------------------------------------------------------------------------
// dmem_responder
//
// Target side of the core's data-memory port. Accepts one load/store at a
// time over a valid/ready request channel, waits WAIT cycles, performs the
// word access on an internal 2**ADDR_W x 32 array, and holds the result on a
// valid/ready response channel until the requester takes it.
//
// State table
//   state   | meaning
//   IDLE    | no transaction; req_ready=1
//   WAIT    | request captured, counting down wait states
//   RESP    | access done, response held until rsp_ready
//
// Ports
//   clk        rising-edge clock
//   reset      asynchronous active-low reset
//   req_valid  request present
//   req_ready  responder can accept (high only in IDLE)
//   req_we     1 = store, 0 = load
//   req_addr   byte address
//   req_wdata  store data
//   req_be     store byte enables (bit i -> bits [8i+7:8i])
//   rsp_valid  response present
//   rsp_ready  requester accepts the response
//   rsp_rdata  load data; 0 for stores and errors
//   rsp_err    misaligned or out-of-range access
//   busy       transaction in progress, registered
// ---------------------------------------------------------------------------
module dmem_responder #(
    parameter int unsigned ADDR_W    = 8,
    parameter int unsigned WAIT      = 2,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int unsigned DEPTH    = 2 ** ADDR_W;
    localparam logic [32:0] BASE_EXT = {1'b0, BASE_ADDR};
    localparam logic [32:0] SPAN_EXT = 33'd4 << ADDR_W;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [3:0]  be_q, be_d;
    logic        rsp_valid_q, rsp_valid_d;
    logic [31:0] rsp_rdata_q, rsp_rdata_d;
    logic        rsp_err_q, rsp_err_d;
    logic        busy_q, busy_d;

    logic [31:0] mem [DEPTH];

    logic              do_access;
    logic              acc_we;
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic [3:0]        acc_be;
    logic [32:0]       acc_off;
    logic              acc_err;
    logic [ADDR_W-1:0] acc_idx;
    logic [31:0]       rd_word;
    logic              mem_we;

    assign req_ready = (state_q == ST_IDLE);

    // With WAIT=0 the access happens on the accepting edge, so the live
    // request fields feed the access path in IDLE; otherwise the captured ones.
    always_comb begin : access_path
        acc_we    = we_q;
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_be    = be_q;
        if (state_q == ST_IDLE) begin
            acc_we    = req_we;
            acc_addr  = req_addr;
            acc_wdata = req_wdata;
            acc_be    = req_be;
        end
        // 33-bit offset: bit 32 flags addr < BASE, and the upper compare
        // cannot wrap for addresses near 32'hFFFF_FFFC.
        acc_off = {1'b0, acc_addr} - BASE_EXT;
        acc_err = (acc_addr[1:0] != 2'b00) | acc_off[32] | (acc_off >= SPAN_EXT);
        acc_idx = acc_err ? '0 : acc_off[ADDR_W+1:2];
        rd_word = mem[acc_idx];
    end

    always_comb begin : fsm_next
        state_d     = state_q;
        cnt_d       = cnt_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        be_d        = be_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
        rsp_err_d   = rsp_err_q;
        do_access   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req_valid) begin
                    we_d    = req_we;
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    be_d    = req_be;
                    cnt_d   = 4'(WAIT);
                    if (WAIT == 0) begin
                        do_access = 1'b1;
                        state_d   = ST_RESP;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    do_access = 1'b1;
                    state_d   = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    state_d     = ST_IDLE;
                    rsp_valid_d = 1'b0;
                    rsp_rdata_d = 32'h0;
                    rsp_err_d   = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (do_access) begin
            rsp_valid_d = 1'b1;
            rsp_err_d   = acc_err;
            rsp_rdata_d = (acc_we || acc_err) ? 32'h0 : rd_word;
        end

        busy_d = (state_d != ST_IDLE);
    end

    assign mem_we = do_access & acc_we & ~acc_err;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 4'd0;
            we_q        <= 1'b0;
            addr_q      <= 32'h0;
            wdata_q     <= 32'h0;
            be_q        <= 4'h0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= 32'h0;
            rsp_err_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            be_q        <= be_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
            rsp_err_q   <= rsp_err_d;
            busy_q      <= busy_d;
        end
    end

    // Array has no reset; a store lands only on its access edge.
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int i = 0; i < 4; i++) begin
                if (acc_be[i]) begin
                    mem[acc_idx][8*i +: 8] <= acc_wdata[8*i +: 8];
                end
            end
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
    assign rsp_err   = rsp_err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;

    localparam int          AW    = 8;
    localparam int          DEPTH = 256;
    localparam int          W0    = 2;
    localparam int          W1    = 0;
    localparam logic [31:0] B0    = 32'h0000_0000;
    localparam logic [31:0] B1    = 32'h0000_1000;

    logic clk = 1'b0;
    logic reset = 1'b0;

    logic        req_valid [2];
    logic        req_ready [2];
    logic        req_we    [2];
    logic [31:0] req_addr  [2];
    logic [31:0] req_wdata [2];
    logic [3:0]  req_be    [2];
    logic        rsp_valid [2];
    logic        rsp_ready [2];
    logic [31:0] rsp_rdata [2];
    logic        rsp_err   [2];
    logic        busy      [2];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    dmem_responder #(.ADDR_W(AW), .WAIT(W0), .BASE_ADDR(B0)) dut0 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[0]), .req_ready(req_ready[0]), .req_we(req_we[0]),
        .req_addr(req_addr[0]), .req_wdata(req_wdata[0]), .req_be(req_be[0]),
        .rsp_valid(rsp_valid[0]), .rsp_ready(rsp_ready[0]), .rsp_rdata(rsp_rdata[0]),
        .rsp_err(rsp_err[0]), .busy(busy[0])
    );

    dmem_responder #(.ADDR_W(AW), .WAIT(W1), .BASE_ADDR(B1)) dut1 (
        .clk(clk), .reset(reset),
        .req_valid(req_valid[1]), .req_ready(req_ready[1]), .req_we(req_we[1]),
        .req_addr(req_addr[1]), .req_wdata(req_wdata[1]), .req_be(req_be[1]),
        .rsp_valid(rsp_valid[1]), .rsp_ready(rsp_ready[1]), .rsp_rdata(rsp_rdata[1]),
        .rsp_err(rsp_err[1]), .busy(busy[1])
    );

    function automatic int wait_of(input int k);
        return (k == 0) ? W0 : W1;
    endfunction

    function automatic logic [31:0] base_of(input int k);
        return (k == 0) ? B0 : B1;
    endfunction

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s[%0d] at %0t: got %h expected %h", name, k, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model (transaction level) ----------------
    bit          m_active [2];
    bit          m_vis    [2];
    int          m_acc    [2];
    logic        m_we     [2];
    logic [31:0] m_addr   [2];
    logic [31:0] m_wdata  [2];
    logic [3:0]  m_be     [2];
    logic [31:0] m_rd     [2];
    bit          m_err    [2];
    logic [31:0] mem_m    [2][DEPTH];
    int          cyc = 0;

    task automatic model_access(input int k);
        longint a, b;
        int     idx;
        a = {32'h0, m_addr[k]};
        b = {32'h0, base_of(k)};
        m_err[k] = (a % 4 != 0) || (a < b) || (a >= b + 4 * DEPTH);
        m_rd[k]  = 32'h0;
        if (!m_err[k]) begin
            idx = int'((a - b) / 4);
            if (m_we[k]) begin
                for (int i = 0; i < 4; i++)
                    if (m_be[k][i]) mem_m[k][idx][8*i +: 8] = m_wdata[k][8*i +: 8];
            end else begin
                m_rd[k] = mem_m[k][idx];
            end
        end
        m_vis[k] = 1'b1;
    endtask

    // A request is accepted when nothing is outstanding; the access lands
    // WAIT edges after acceptance; the response retires on rsp_ready.
    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int k = 0; k < 2; k++) begin
                m_active[k] = 1'b0;
                m_vis[k]    = 1'b0;
            end
        end else begin
            cyc++;
            for (int k = 0; k < 2; k++) begin
                if (m_active[k]) begin
                    if (m_vis[k]) begin
                        if (rsp_ready[k]) begin
                            m_active[k] = 1'b0;
                            m_vis[k]    = 1'b0;
                        end
                    end else if (cyc == m_acc[k] + wait_of(k)) begin
                        model_access(k);
                    end
                end else if (req_valid[k]) begin
                    m_active[k] = 1'b1;
                    m_acc[k]    = cyc;
                    m_we[k]     = req_we[k];
                    m_addr[k]   = req_addr[k];
                    m_wdata[k]  = req_wdata[k];
                    m_be[k]     = req_be[k];
                    if (wait_of(k) == 0) model_access(k);
                end
            end
        end
    end

    // ---------------- per-cycle compare ----------------
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            check("req_ready", k, {31'h0, req_ready[k]}, {31'h0, !m_active[k]});
            check("busy",      k, {31'h0, busy[k]},      {31'h0, m_active[k]});
            check("rsp_valid", k, {31'h0, rsp_valid[k]}, {31'h0, m_vis[k]});
            check("rsp_rdata", k, rsp_rdata[k], m_vis[k] ? m_rd[k] : 32'h0);
            check("rsp_err",   k, {31'h0, rsp_err[k]},   {31'h0, m_vis[k] && m_err[k]});
        end
    end

    // ---------------- driver ----------------
    // Called at a negedge with the target idle; returns at the negedge after
    // the response handshake. lat counts negedges from acceptance until
    // rsp_valid is seen; ncyc counts all negedges spent.
    task automatic txn(input int k, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic [3:0] be, input int hold,
                       output logic [31:0] rd, output logic er, output int lat,
                       output int ncyc, output logic bsy);
        req_valid[k] = 1'b1;
        req_we[k]    = we;
        req_addr[k]  = addr;
        req_wdata[k] = wdata;
        req_be[k]    = be;
        rsp_ready[k] = (hold == 0);
        @(posedge clk);
        @(negedge clk);
        lat  = 1;
        ncyc = 1;
        while (!rsp_valid[k] && lat < 40) begin
            req_valid[k] = 1'($urandom);
            req_we[k]    = 1'($urandom);
            req_addr[k]  = $urandom;
            req_wdata[k] = $urandom;
            req_be[k]    = 4'($urandom);
            @(negedge clk);
            lat++;
            ncyc++;
        end
        check("rsp_timeout", k, {31'h0, rsp_valid[k]}, 32'h1);
        rd  = rsp_rdata[k];
        er  = rsp_err[k];
        bsy = busy[k];
        for (int h = 0; h < hold; h++) begin
            req_valid[k] = 1'b1;
            req_addr[k]  = $urandom;
            @(negedge clk);
            ncyc++;
        end
        rsp_ready[k] = 1'b1;
        @(posedge clk);
        @(negedge clk);
        ncyc++;
        req_valid[k] = 1'b0;
        rsp_ready[k] = 1'b0;
    endtask

    function automatic logic [31:0] rand_addr(input int k);
        logic [31:0] b;
        int r;
        b = base_of(k);
        r = $urandom_range(0, 9);
        if (r < 7)       return b + 32'(4 * $urandom_range(0, 255));
        else if (r == 7) return b + 32'(4 * $urandom_range(0, 255)) + 32'($urandom_range(1, 3));
        else if (r == 8) return b + 32'h400 + 32'(4 * $urandom_range(0, 15));
        else             return (k == 1) ? b - 32'(4 * $urandom_range(1, 4)) : 32'hFFFF_FFFC;
    endfunction

    logic [31:0] rd;
    logic        er, bs;
    int          lat, nc;

    initial begin
        for (int k = 0; k < 2; k++) begin
            req_valid[k] = 1'b0;
            req_we[k]    = 1'b0;
            req_addr[k]  = 32'h0;
            req_wdata[k] = 32'h0;
            req_be[k]    = 4'h0;
            rsp_ready[k] = 1'b0;
        end
        repeat (3) @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);

        // fill both arrays so every later load has a defined value
        for (int k = 0; k < 2; k++)
            for (int i = 0; i < DEPTH; i++)
                txn(k, 1'b1, base_of(k) + 32'(4 * i), $urandom, 4'hF, 0, rd, er, lat, nc, bs);

        // ---- instance 0: WAIT=2, BASE=0 ----
        txn(0, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, nc, bs);
        check("st_err", 0, {31'h0, er}, 32'h0);
        check("st_rdata", 0, rd, 32'h0);
        check("st_latency", 0, lat, 32'd3);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, nc, bs);
        check("ld_deadbeef", 0, rd, 32'hDEADBEEF);

        // reset in WAIT drops a pending store to 0x10
        req_valid[0] = 1'b1; req_we[0] = 1'b1; req_addr[0] = 32'h10;
        req_wdata[0] = 32'h12345678; req_be[0] = 4'hF;
        @(posedge clk);
        @(negedge clk);
        req_valid[0] = 1'b0;
        #1 reset = 1'b0;
        @(negedge clk);
        #1 reset = 1'b1;
        @(negedge clk);
        check("rst_req_ready", 0, {31'h0, req_ready[0]}, 32'h1);
        check("rst_busy", 0, {31'h0, busy[0]}, 32'h0);
        check("rst_rsp_valid", 0, {31'h0, rsp_valid[0]}, 32'h0);
        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 0, rd, er, lat, nc, bs);
        check("rst_no_commit", 0, rd, 32'hDEADBEEF);

        txn(0, 1'b1, 32'h4, 32'h11223344, 4'hF, 0, rd, er, lat, nc, bs);
        txn(0, 1'b1, 32'h4, 32'hAABBCCDD, 4'b0101, 0, rd, er, lat, nc, bs);
        txn(0, 1'b0, 32'h4, 32'h0, 4'h0, 0, rd, er, lat, nc, bs);
        check("byte_enable", 0, rd, 32'h11BB33DD);

        txn(0, 1'b0, 32'h6, 32'h0, 4'h0, 0, rd, er, lat, nc, bs);
        check("misalign_err", 0, {31'h0, er}, 32'h1);
        check("misalign_rdata", 0, rd, 32'h0);

        txn(0, 1'b1, 32'h0, 32'hCAFEF00D, 4'hF, 0, rd, er, lat, nc, bs);
        txn(0, 1'b1, 32'h400, 32'h0BADBAD0, 4'hF, 0, rd, er, lat, nc, bs);
        check("range_err", 0, {31'h0, er}, 32'h1);
        txn(0, 1'b0, 32'h0, 32'h0, 4'h0, 0, rd, er, lat, nc, bs);
        check("range_no_write", 0, rd, 32'hCAFEF00D);

        txn(0, 1'b0, 32'hFFFF_FFFC, 32'h0, 4'h0, 0, rd, er, lat, nc, bs);
        check("top_addr_err", 0, {31'h0, er}, 32'h1);

        txn(0, 1'b1, 32'h8, 32'h01020304, 4'hF, 0, rd, er, lat, nc, bs);
        txn(0, 1'b1, 32'h8, 32'hFFFFFFFF, 4'h0, 0, rd, er, lat, nc, bs);
        check("be0_err", 0, {31'h0, er}, 32'h0);
        txn(0, 1'b0, 32'h8, 32'h0, 4'h0, 0, rd, er, lat, nc, bs);
        check("be0_unchanged", 0, rd, 32'h01020304);

        txn(0, 1'b0, 32'h10, 32'h0, 4'h0, 5, rd, er, lat, nc, bs);
        check("bp_rdata", 0, rd, 32'hDEADBEEF);
        check("bp_cycles", 0, nc, 32'd9);

        // ---- instance 1: WAIT=0, BASE=0x1000 ----
        txn(1, 1'b1, 32'h1010, 32'hDEADBEEF, 4'hF, 0, rd, er, lat, nc, bs);
        check("w0_latency", 1, lat, 32'd1);
        txn(1, 1'b0, 32'h1010, 32'h0, 4'h0, 0, rd, er, lat, nc, bs);
        check("w0_load", 1, rd, 32'hDEADBEEF);
        txn(1, 1'b0, 32'h0010, 32'h0, 4'h0, 0, rd, er, lat, nc, bs);
        check("below_base_err", 1, {31'h0, er}, 32'h1);
        txn(1, 1'b0, 32'h1400, 32'h0, 4'h0, 0, rd, er, lat, nc, bs);
        check("above_top_err", 1, {31'h0, er}, 32'h1);

        for (int i = 0; i < 8; i++) begin
            txn(1, 1'b0, B1 + 32'(4 * i), 32'h0, 4'h0, 0, rd, er, lat, nc, bs);
            check("tput_latency", 1, lat, 32'd1);
            check("tput_cycles", 1, nc, 32'd2);
            check("tput_busy_hi", 1, {31'h0, bs}, 32'h1);
            check("tput_busy_lo", 1, {31'h0, busy[1]}, 32'h0);
        end

        // ---- randomized traffic on both instances ----
        for (int k = 0; k < 2; k++) begin
            for (int n = 0; n < 150; n++) begin
                txn(k, 1'($urandom), rand_addr(k), $urandom, 4'($urandom),
                    $urandom_range(0, 4), rd, er, lat, nc, bs);
                repeat ($urandom_range(0, 2)) @(negedge clk);
            end
        end

        repeat (2) @(negedge clk);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule
